// File: rtl/operand_fetch_unit_if.sv
// ID-to-EX handshake bundle for the operand fetch unit.
// The master side issues decoded requests and consumes operands; the slave is the unit.
interface operand_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic            id_ready;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_rd_wen;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [4:0]      ex_rd;
    logic            ex_rd_wen;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rd_wen, ex_ready,
        input  id_ready, ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_wen
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rd_wen, ex_ready,
        output id_ready, ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_wen
    );
endinterface

// File: rtl/operand_fetch_unit.sv
// Operand fetch: selects register-bank operands with write-back bypass, tracks
// in-flight destinations in a scoreboard and stalls RAW/WAW hazards.
module operand_fetch_unit #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    operand_fetch_unit_if.slave  bus,
    input  logic [32*XLEN-1:0]   x_rdata,
    input  logic                 wb_wen,
    input  logic [4:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic [31:0]          pend
);

    function automatic logic wb_hit(input logic [4:0] r, input logic wen,
                                    input logic [4:0] wrd);
        return wen && (wrd == r) && (r != 5'd0);
    endfunction

    logic [31:0]     pend_q, pend_nxt;
    logic            ex_valid_q;
    logic [XLEN-1:0] rs1_data_q, rs2_data_q;
    logic [4:0]      rd_q;
    logic            rd_wen_q;

    logic            hit_rs1, hit_rs2, hit_rd, hit_wb;
    logic            blk_rs1, blk_rs2, blk_waw;
    logic            ready, xfer, kill_ex;
    logic [XLEN-1:0] rs1_sel, rs2_sel;

    // Hazard detection and handshake; id_ready never looks at id_valid.
    always_comb begin
        hit_rs1 = wb_hit(bus.id_rs1, wb_wen, wb_rd);
        hit_rs2 = wb_hit(bus.id_rs2, wb_wen, wb_rd);
        hit_rd  = wb_hit(bus.id_rd,  wb_wen, wb_rd);
        hit_wb  = wb_hit(wb_rd,      wb_wen, wb_rd);

        blk_rs1 = (bus.id_rs1 != 5'd0) && pend_q[bus.id_rs1] && !(FWD_EN && hit_rs1);
        blk_rs2 = (bus.id_rs2 != 5'd0) && pend_q[bus.id_rs2] && !(FWD_EN && hit_rs2);
        blk_waw = bus.id_rd_wen && (bus.id_rd != 5'd0) && pend_q[bus.id_rd] && !hit_rd;

        ready   = !flush && (!ex_valid_q || bus.ex_ready) && !blk_rs1 && !blk_rs2 && !blk_waw;
        xfer    = bus.id_valid && ready;
        kill_ex = flush && ex_valid_q && rd_wen_q && (rd_q != 5'd0);
    end

    // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rs1_sel = '0;
        rs2_sel = '0;
        if (bus.id_rs1 != 5'd0) begin
            rs1_sel = (FWD_EN && hit_rs1) ? wb_data : x_rdata[bus.id_rs1*XLEN +: XLEN];
        end
        if (bus.id_rs2 != 5'd0) begin
            rs2_sel = (FWD_EN && hit_rs2) ? wb_data : x_rdata[bus.id_rs2*XLEN +: XLEN];
        end
    end

    // Later assignments override earlier ones, so a same-cycle set beats any clear.
    always_comb begin
        pend_nxt = pend_q;
        if (hit_wb) begin
            pend_nxt[wb_rd] = 1'b0;
        end
        if (kill_ex) begin
            pend_nxt[rd_q] = 1'b0;
        end
        if (xfer && bus.id_rd_wen && (bus.id_rd != 5'd0)) begin
            pend_nxt[bus.id_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ex_valid_q <= 1'b0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (xfer) begin
            ex_valid_q <= 1'b1;
        end else if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    // Operand registers only move on a transfer; they hold through drain, stall and flush.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_q       <= '0;
            rd_wen_q   <= 1'b0;
        end else if (xfer) begin
            rs1_data_q <= rs1_sel;
            rs2_data_q <= rs2_sel;
            rd_q       <= bus.id_rd;
            rd_wen_q   <= bus.id_rd_wen;
        end
    end

    assign bus.id_ready    = ready;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_rs1_data = rs1_data_q;
    assign bus.ex_rs2_data = rs2_data_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_rd_wen   = rd_wen_q;
    assign pend            = pend_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench: forwarding instance covers the full flow, a second instance
// without forwarding covers the RAW stall-until-write-back case.
module tb_operand_fetch_unit;
    localparam int XLEN = 32;

    logic               CLK = 1'b0;
    logic               RSTN;
    logic [32*XLEN-1:0] x_rdata;

    logic               wb_wen, wb_wen0;
    logic [4:0]         wb_rd, wb_rd0;
    logic [XLEN-1:0]    wb_data, wb_data0;
    logic               flush, flush0;
    logic [31:0]        pend, pend0;

    int tests = 0;
    int fails = 0;

    operand_fetch_unit_if #(.XLEN(XLEN)) bus  ();
    operand_fetch_unit_if #(.XLEN(XLEN)) bus0 ();

    operand_fetch_unit #(.XLEN(XLEN), .FWD_EN(1'b1)) dut (
        .CLK(CLK), .RSTN(RSTN), .bus(bus), .x_rdata(x_rdata),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .pend(pend)
    );

    operand_fetch_unit #(.XLEN(XLEN), .FWD_EN(1'b0)) dut0 (
        .CLK(CLK), .RSTN(RSTN), .bus(bus0), .x_rdata(x_rdata),
        .wb_wen(wb_wen0), .wb_rd(wb_rd0), .wb_data(wb_data0),
        .flush(flush0), .pend(pend0)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are then stable.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen);
        bus.id_valid  = v;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.id_rd     = rd;
        bus.id_rd_wen = wen;
    endtask

    task automatic issue0(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wen);
        bus0.id_valid  = v;
        bus0.id_rs1    = rs1;
        bus0.id_rs2    = rs2;
        bus0.id_rd     = rd;
        bus0.id_rd_wen = wen;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            x_rdata[i*XLEN +: XLEN] = 32'h1000_0000 + i;
        end
        x_rdata[0*XLEN +: XLEN] = 32'hFFFF_FFFF;
        x_rdata[5*XLEN +: XLEN] = 32'h1234_5678;
        x_rdata[7*XLEN +: XLEN] = 32'hDEAD_BEEF;

        RSTN = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        issue0(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        bus.ex_ready = 1'b1;  bus0.ex_ready = 1'b1;
        wb_wen = 1'b0;  wb_rd = '0;  wb_data = '0;  flush = 1'b0;
        wb_wen0 = 1'b0; wb_rd0 = '0; wb_data0 = '0; flush0 = 1'b0;

        // Reset and idle
        tick(); tick();
        check("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("rst_pend", 64'(pend), 64'd0);
        check("rst_rs1_data", 64'(bus.ex_rs1_data), 64'd0);
        check("rst_rd_wen", 64'(bus.ex_rd_wen), 64'd0);
        RSTN = 1'b1;
        tick();
        check("idle_id_ready", 64'(bus.id_ready), 64'd1);
        check("idle_ex_valid", 64'(bus.ex_valid), 64'd0);

        // Basic read
        issue(1'b1, 5'd5, 5'd7, 5'd9, 1'b1);
        #1 check("basic_id_ready", 64'(bus.id_ready), 64'd1);
        tick();
        check("basic_ex_valid", 64'(bus.ex_valid), 64'd1);
        check("basic_rs1", 64'(bus.ex_rs1_data), 64'h1234_5678);
        check("basic_rs2", 64'(bus.ex_rs2_data), 64'hDEAD_BEEF);
        check("basic_rd", 64'(bus.ex_rd), 64'd9);
        check("basic_pend", 64'(pend), 64'h200);

        // RAW hazard on x9, resolved by forwarded write-back
        issue(1'b1, 5'd9, 5'd0, 5'd10, 1'b1);
        #1 check("raw_stall", 64'(bus.id_ready), 64'd0);
        tick();
        check("raw_drain_valid", 64'(bus.ex_valid), 64'd0);
        check("raw_hold_rs1", 64'(bus.ex_rs1_data), 64'h1234_5678);
        wb_wen = 1'b1; wb_rd = 5'd9; wb_data = 32'hA5A5_0001;
        #1 check("raw_fwd_ready", 64'(bus.id_ready), 64'd1);
        tick();
        check("raw_fwd_valid", 64'(bus.ex_valid), 64'd1);
        check("raw_fwd_rs1", 64'(bus.ex_rs1_data), 64'hA5A5_0001);
        check("raw_fwd_rs2", 64'(bus.ex_rs2_data), 64'd0);
        check("raw_pend", 64'(pend), 64'h400);

        // x0: reads return 0 even with a wb to x0, writes never set pend
        issue(1'b1, 5'd0, 5'd5, 5'd0, 1'b1);
        wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_0055;
        #1 check("x0_ready", 64'(bus.id_ready), 64'd1);
        tick();
        wb_wen = 1'b0;
        check("x0_rs1", 64'(bus.ex_rs1_data), 64'd0);
        check("x0_rs2", 64'(bus.ex_rs2_data), 64'h1234_5678);
        check("x0_pend", 64'(pend), 64'h400);

        // Back-pressure: outputs frozen, no acceptance
        bus.ex_ready = 1'b0;
        issue(1'b1, 5'd7, 5'd0, 5'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_id_ready", 64'(bus.id_ready), 64'd0);
            tick();
            check("bp_ex_valid", 64'(bus.ex_valid), 64'd1);
            check("bp_rs2", 64'(bus.ex_rs2_data), 64'h1234_5678);
            check("bp_rd", 64'(bus.ex_rd), 64'd0);
        end
        check("bp_pend", 64'(pend), 64'h400);

        // WAW on x3: second writer waits for the first write-back
        bus.ex_ready = 1'b1;
        #1 check("waw_first_ready", 64'(bus.id_ready), 64'd1);
        tick();
        check("waw_first_rs1", 64'(bus.ex_rs1_data), 64'hDEAD_BEEF);
        check("waw_first_rd", 64'(bus.ex_rd), 64'd3);
        check("waw_first_pend", 64'(pend), 64'h408);
        issue(1'b1, 5'd5, 5'd0, 5'd3, 1'b1);
        #1 check("waw_stall", 64'(bus.id_ready), 64'd0);
        tick();
        check("waw_stall_valid", 64'(bus.ex_valid), 64'd0);
        check("waw_stall_pend", 64'(pend), 64'h408);
        #1 check("waw_still_stall", 64'(bus.id_ready), 64'd0);
        wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0077;
        #1 check("waw_release", 64'(bus.id_ready), 64'd1);
        tick();
        wb_wen = 1'b0;
        check("waw_second_valid", 64'(bus.ex_valid), 64'd1);
        check("waw_second_rs1", 64'(bus.ex_rs1_data), 64'h1234_5678);
        check("waw_second_pend", 64'(pend), 64'h408);

        // Flush kills the EX entry for x4 and releases its pend bit
        issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
        tick();
        check("fl_rd", 64'(bus.ex_rd), 64'd4);
        check("fl_pre_pend", 64'(pend), 64'h418);
        issue(1'b1, 5'd0, 5'd0, 5'd12, 1'b1);
        bus.ex_ready = 1'b0;
        flush = 1'b1;
        #1 check("fl_id_ready", 64'(bus.id_ready), 64'd0);
        tick();
        flush = 1'b0;
        bus.ex_ready = 1'b1;
        check("fl_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("fl_pend", 64'(pend), 64'h408);

        // Same-cycle set of x6 by transfer and clear by write-back: set wins
        issue(1'b1, 5'd0, 5'd0, 5'd6, 1'b1);
        wb_wen = 1'b1; wb_rd = 5'd6; wb_data = 32'h0000_0066;
        tick();
        wb_wen = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("setwin_pend", 64'(pend), 64'h448);

        // Asynchronous reset mid-operation
        #2 RSTN = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.ex_valid), 64'd0);
        check("mid_rst_pend", 64'(pend), 64'd0);
        check("mid_rst_rd", 64'(bus.ex_rd), 64'd0);
        tick();
        RSTN = 1'b1;
        tick();

        // Without forwarding: RAW waits one cycle past the write-back
        issue0(1'b1, 5'd5, 5'd7, 5'd9, 1'b1);
        tick();
        check("nf_basic_rs1", 64'(bus0.ex_rs1_data), 64'h1234_5678);
        check("nf_basic_pend", 64'(pend0), 64'h200);
        issue0(1'b1, 5'd9, 5'd0, 5'd10, 1'b1);
        #1 check("nf_raw_stall", 64'(bus0.id_ready), 64'd0);
        tick();
        wb_wen0 = 1'b1; wb_rd0 = 5'd9; wb_data0 = 32'hA5A5_0001;
        #1 check("nf_wb_stall", 64'(bus0.id_ready), 64'd0);
        tick();
        wb_wen0 = 1'b0;
        x_rdata[9*XLEN +: XLEN] = 32'hA5A5_0001;
        check("nf_pend_clear", 64'(pend0), 64'd0);
        check("nf_not_taken", 64'(bus0.ex_valid), 64'd0);
        #1 check("nf_ready", 64'(bus0.id_ready), 64'd1);
        tick();
        issue0(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("nf_valid", 64'(bus0.ex_valid), 64'd1);
        check("nf_rs1", 64'(bus0.ex_rs1_data), 64'hA5A5_0001);
        check("nf_pend", 64'(pend0), 64'h400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
